// File: rtl/axi4lite_responder_mem_if.sv
// AXI4-Lite bus bundle between a manager and the responder memory.
interface axi4lite_responder_mem_if #(
    parameter int AddressWidth = 20,
    parameter int DataWidth    = 32
);
    logic                      awvalid;
    logic                      awready;
    logic [AddressWidth-1:0]   awaddr;
    logic [2:0]                awprot;
    logic                      wvalid;
    logic                      wready;
    logic [DataWidth-1:0]      wdata;
    logic [DataWidth/8-1:0]    wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [AddressWidth-1:0]   araddr;
    logic [2:0]                arprot;
    logic                      rvalid;
    logic                      rready;
    logic [DataWidth-1:0]      rdata;
    logic [1:0]                rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi4lite_responder_mem.sv
// AXI4-Lite subordinate backed by a word-addressed memory, with programmable
// wait states per channel and SLVERR for accesses outside the mapped window.
module axi4lite_responder_mem #(
    parameter int                    AddressWidth = 20,
    parameter int                    DataWidth    = 32,
    parameter int                    MemoryDepth  = 1024,
    parameter logic [AddressWidth-1:0] BaseAddress = '0,
    parameter int                    ReadLatency  = 2,
    parameter int                    WriteLatency = 1
) (
    input  logic                       clk,
    input  logic                       areset_n,
    axi4lite_responder_mem_if.slave    bus_io
);
    localparam int IDX_W  = $clog2(MemoryDepth);
    localparam int STRB_W = DataWidth / 8;
    localparam logic [3:0] WR_LAT = 4'(WriteLatency);
    localparam logic [3:0] RD_LAT = 4'(ReadLatency);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (DataWidth != 32) begin : g_bad_width
        $error("axi4lite_responder_mem: only DataWidth=32 is supported");
    end
    if (MemoryDepth < 2) begin : g_bad_depth
        $error("axi4lite_responder_mem: MemoryDepth must be at least 2");
    end
    if (ReadLatency < 0 || ReadLatency > 15 || WriteLatency < 0 || WriteLatency > 15) begin : g_bad_lat
        $error("axi4lite_responder_mem: latencies must be in 0..15");
    end

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;

    logic [DataWidth-1:0] mem_q [MemoryDepth];

    // ---------------- write channel signals ----------------
    wr_state_t               wr_state_q, wr_state_d;
    logic [3:0]              wr_cnt_q, wr_cnt_d;
    logic                    aw_cap_q, aw_cap_d, w_cap_q, w_cap_d;
    logic                    awready_q, awready_d, wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [AddressWidth-1:0] awaddr_q;
    logic [DataWidth-1:0]    wdata_q;
    logic [STRB_W-1:0]       wstrb_q;
    logic                    aw_hs, w_hs, wr_commit;
    logic [AddressWidth-1:0] wr_addr_eff;
    logic [DataWidth-1:0]    wr_data_eff;
    logic [STRB_W-1:0]       wr_strb_eff;
    logic [AddressWidth:0]   wr_offset;
    logic                    wr_in_range;
    logic [IDX_W-1:0]        wr_idx;

    // ---------------- read channel signals ----------------
    rd_state_t               rd_state_q, rd_state_d;
    logic [3:0]              rd_cnt_q, rd_cnt_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [DataWidth-1:0]    rdata_q;
    logic [AddressWidth-1:0] araddr_q;
    logic                    ar_hs, rd_sample;
    logic [AddressWidth-1:0] rd_addr_eff;
    logic [AddressWidth:0]   rd_offset;
    logic                    rd_in_range;
    logic [IDX_W-1:0]        rd_idx;

    assign aw_hs = bus_io.awvalid && awready_q;
    assign w_hs  = bus_io.wvalid  && wready_q;
    assign ar_hs = bus_io.arvalid && arready_q;

    // Forward live bus values so a zero-latency commit/sample sees the beat
    // that is being captured in the same cycle.
    assign wr_addr_eff = aw_hs ? bus_io.awaddr : awaddr_q;
    assign wr_data_eff = w_hs  ? bus_io.wdata  : wdata_q;
    assign wr_strb_eff = w_hs  ? bus_io.wstrb  : wstrb_q;
    assign rd_addr_eff = ar_hs ? bus_io.araddr : araddr_q;

    // Decode: subtract in one extra bit so addresses below the base show up as a borrow.
    assign wr_offset   = {1'b0, wr_addr_eff} - {1'b0, BaseAddress};
    assign wr_in_range = !wr_offset[AddressWidth] &&
                         (32'(wr_offset[AddressWidth-1:2]) < 32'(MemoryDepth));
    assign wr_idx      = wr_offset[IDX_W+1:2];
    assign rd_offset   = {1'b0, rd_addr_eff} - {1'b0, BaseAddress};
    assign rd_in_range = !rd_offset[AddressWidth] &&
                         (32'(rd_offset[AddressWidth-1:2]) < 32'(MemoryDepth));
    assign rd_idx      = rd_offset[IDX_W+1:2];

    logic unused_bits;
    assign unused_bits = ^{bus_io.awprot, bus_io.arprot, wr_offset[1:0], rd_offset[1:0]};

    // Write FSM state register and registered write-channel outputs.
    always_ff @(posedge clk) begin
        if (!areset_n) begin
            wr_state_q <= W_IDLE;
            wr_cnt_q   <= '0;
            aw_cap_q   <= 1'b0;
            w_cap_q    <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            wr_cnt_q   <= wr_cnt_d;
            aw_cap_q   <= aw_cap_d;
            w_cap_q    <= w_cap_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
        end
    end

    // Capture AW and W beats independently as each handshake completes.
    always_ff @(posedge clk) begin
        if (aw_hs) awaddr_q <= bus_io.awaddr;
        if (w_hs) begin
            wdata_q <= bus_io.wdata;
            wstrb_q <= bus_io.wstrb;
        end
    end

    // Write FSM next state: wait for both beats, count wait states, hold response.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        aw_cap_d   = aw_cap_q || aw_hs;
        w_cap_d    = w_cap_q  || w_hs;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_cap_d && w_cap_d) begin
                    wr_cnt_d   = WR_LAT;
                    wr_state_d = (WriteLatency == 0) ? W_RESP : W_WAIT;
                end
            end
            W_WAIT: begin
                if (wr_cnt_q == 4'd0) wr_state_d = W_RESP;
                else                  wr_cnt_d   = wr_cnt_q - 4'd1;
            end
            W_RESP: begin
                if (bus_io.bready) begin
                    wr_state_d = W_IDLE;
                    aw_cap_d   = 1'b0;
                    w_cap_d    = 1'b0;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Write FSM outputs: readies, commit strobe on entry to W_RESP, response code.
    always_comb begin
        wr_commit = areset_n && (wr_state_q != W_RESP) && (wr_state_d == W_RESP);
        awready_d = (wr_state_d == W_IDLE) && !aw_cap_d;
        wready_d  = (wr_state_d == W_IDLE) && !w_cap_d;
        bvalid_d  = (wr_state_d == W_RESP);
        bresp_d   = bresp_q;
        if (wr_commit)                 bresp_d = wr_in_range ? RESP_OKAY : RESP_SLVERR;
        else if (wr_state_d != W_RESP) bresp_d = RESP_OKAY;
    end

    // Byte-enabled memory write at commit; out-of-range commits touch nothing.
    always_ff @(posedge clk) begin
        if (wr_commit && wr_in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb_eff[b]) mem_q[wr_idx][8*b +: 8] <= wr_data_eff[8*b +: 8];
            end
        end
    end

    // Read FSM state register and registered read-channel outputs.
    always_ff @(posedge clk) begin
        if (!areset_n) begin
            rd_state_q <= R_IDLE;
            rd_cnt_q   <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            rd_cnt_q   <= rd_cnt_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
        end
    end

    // Capture the read address on the AR handshake.
    always_ff @(posedge clk) begin
        if (ar_hs) araddr_q <= bus_io.araddr;
    end

    // Read FSM next state: accept address, count wait states, hold response.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_cnt_d   = RD_LAT;
                    rd_state_d = (ReadLatency == 0) ? R_RESP : R_WAIT;
                end
            end
            R_WAIT: begin
                if (rd_cnt_q == 4'd0) rd_state_d = R_RESP;
                else                  rd_cnt_d   = rd_cnt_q - 4'd1;
            end
            R_RESP: begin
                if (bus_io.rready) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Read FSM outputs: ready, sample strobe on entry to R_RESP, response code.
    always_comb begin
        rd_sample = areset_n && (rd_state_q != R_RESP) && (rd_state_d == R_RESP);
        arready_d = (rd_state_d == R_IDLE);
        rvalid_d  = (rd_state_d == R_RESP);
        rresp_d   = rresp_q;
        if (rd_sample)                 rresp_d = rd_in_range ? RESP_OKAY : RESP_SLVERR;
        else if (rd_state_d != R_RESP) rresp_d = RESP_OKAY;
    end

    // Registered memory read; old data wins when a commit hits the same word.
    always_ff @(posedge clk) begin
        if (!areset_n)      rdata_q <= '0;
        else if (rd_sample) rdata_q <= rd_in_range ? mem_q[rd_idx] : '0;
    end

    assign bus_io.awready = awready_q;
    assign bus_io.wready  = wready_q;
    assign bus_io.bvalid  = bvalid_q;
    assign bus_io.bresp   = bresp_q;
    assign bus_io.arready = arready_q;
    assign bus_io.rvalid  = rvalid_q;
    assign bus_io.rresp   = rresp_q;
    assign bus_io.rdata   = rdata_q;
endmodule

// File: tb/tb_axi4lite_responder_mem.sv
// Directed bench for the AXI4-Lite responder memory with default parameters.
module tb_axi4lite_responder_mem;
    logic clk = 1'b0;
    logic areset_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    axi4lite_responder_mem_if #(.AddressWidth(20), .DataWidth(32)) bus ();

    axi4lite_responder_mem #(
        .AddressWidth(20), .DataWidth(32), .MemoryDepth(1024),
        .BaseAddress(20'h0), .ReadLatency(2), .WriteLatency(1)
    ) u_dut (
        .clk      (clk),
        .areset_n (areset_n),
        .bus_io   (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [19:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
        int n;
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        check_val("wr_awready_pre", 32'(bus.awready), 32'd1);
        check_val("wr_wready_pre", 32'(bus.wready), 32'd1);
        tick;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check_val("wr_awready_post", 32'(bus.awready), 32'd0);
        check_val("wr_wready_post", 32'(bus.wready), 32'd0);
        n = 0;
        while (!bus.bvalid && n < 20) begin
            tick;
            n++;
        end
        check_val("wr_latency", 32'(n), 32'd2);
        check_val("wr_bresp", 32'(bus.bresp), 32'(exp_resp));
        bus.bready = 1'b1;
        tick;
        bus.bready = 1'b0;
        check_val("wr_bvalid_clr", 32'(bus.bvalid), 32'd0);
        check_val("wr_awready_back", 32'(bus.awready), 32'd1);
        $display("[TB] write addr=0x%05h data=0x%08h strb=0x%h bresp=%0d latency=%0d",
                 addr, data, strb, exp_resp, n);
    endtask

    task automatic do_read(input logic [19:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
        int n;
        bus.araddr = addr; bus.arvalid = 1'b1;
        check_val("rd_arready_pre", 32'(bus.arready), 32'd1);
        tick;
        bus.arvalid = 1'b0;
        check_val("rd_arready_post", 32'(bus.arready), 32'd0);
        n = 0;
        while (!bus.rvalid && n < 20) begin
            tick;
            n++;
        end
        check_val("rd_latency", 32'(n), 32'd3);
        check_val("rd_rdata", bus.rdata, exp_data);
        check_val("rd_rresp", 32'(bus.rresp), 32'(exp_resp));
        bus.rready = 1'b1;
        tick;
        bus.rready = 1'b0;
        check_val("rd_rvalid_clr", 32'(bus.rvalid), 32'd0);
        check_val("rd_arready_back", 32'(bus.arready), 32'd1);
        $display("[TB] read  addr=0x%05h rdata=0x%08h rresp=%0d latency=%0d",
                 addr, bus.rdata, bus.rresp, n);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = '0;
        bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = '0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = '0;
        bus.rready  = 1'b0;

        // Reset state
        areset_n = 1'b0;
        tick; tick; tick;
        check_val("rst_awready", 32'(bus.awready), 32'd0);
        check_val("rst_wready", 32'(bus.wready), 32'd0);
        check_val("rst_arready", 32'(bus.arready), 32'd0);
        check_val("rst_bvalid", 32'(bus.bvalid), 32'd0);
        check_val("rst_rvalid", 32'(bus.rvalid), 32'd0);
        check_val("rst_bresp", 32'(bus.bresp), 32'd0);
        check_val("rst_rresp", 32'(bus.rresp), 32'd0);
        check_val("rst_rdata", bus.rdata, 32'd0);
        areset_n = 1'b1;
        tick;
        check_val("rel_awready", 32'(bus.awready), 32'd1);
        check_val("rel_arready", 32'(bus.arready), 32'd1);
        $display("[TB] reset released");

        // Basic write then read
        do_write(20'h00010, 32'hDEADBEEF, 4'hF, 2'b00);
        do_read(20'h00010, 32'hDEADBEEF, 2'b00);

        // Byte strobes: bytes 0 and 2 replaced
        do_write(20'h00020, 32'h11223344, 4'hF, 2'b00);
        do_write(20'h00020, 32'hAABBCCDD, 4'h5, 2'b00);
        do_read(20'h00020, 32'h11BB33DD, 2'b00);

        // Split ordering: W three cycles ahead of AW
        do_write(20'h00030, 32'h55555555, 4'hF, 2'b00);
        bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick;
        bus.wvalid = 1'b0;
        check_val("split_wready_low", 32'(bus.wready), 32'd0);
        check_val("split_awready_high", 32'(bus.awready), 32'd1);
        tick;
        check_val("split_no_bvalid1", 32'(bus.bvalid), 32'd0);
        tick;
        check_val("split_no_bvalid2", 32'(bus.bvalid), 32'd0);
        check_val("split_awready_still", 32'(bus.awready), 32'd1);
        bus.awaddr = 20'h00030; bus.awvalid = 1'b1;
        tick;
        bus.awvalid = 1'b0;
        check_val("split_awready_low", 32'(bus.awready), 32'd0);
        tick;
        check_val("split_bvalid_early", 32'(bus.bvalid), 32'd0);
        tick;
        check_val("split_bvalid", 32'(bus.bvalid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick;
            check_val("split_bvalid_hold", 32'(bus.bvalid), 32'd1);
            check_val("split_bresp_hold", 32'(bus.bresp), 32'd0);
        end
        bus.bready = 1'b1;
        tick;
        bus.bready = 1'b0;
        check_val("split_bvalid_clr", 32'(bus.bvalid), 32'd0);
        $display("[TB] split write addr=0x00030 data=0xcafef00d");
        do_read(20'h00030, 32'hCAFEF00D, 2'b00);

        // Out of range: first address past the window must not alias word 0
        do_write(20'h00000, 32'h0BADF00D, 4'hF, 2'b00);
        do_write(20'h01000, 32'h12345678, 4'hF, 2'b10);
        do_read(20'h00000, 32'h0BADF00D, 2'b00);
        do_read(20'h01000, 32'h00000000, 2'b10);

        // Concurrent read and write with read backpressure
        bus.awaddr = 20'h00040; bus.wdata = 32'h01020304; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 20'h00010; bus.arvalid = 1'b1;
        tick;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        check_val("cc_arready_low", 32'(bus.arready), 32'd0);
        tick;
        check_val("cc_bvalid_early", 32'(bus.bvalid), 32'd0);
        tick;
        check_val("cc_bvalid", 32'(bus.bvalid), 32'd1);
        check_val("cc_rvalid_early", 32'(bus.rvalid), 32'd0);
        bus.bready = 1'b1;
        tick;
        bus.bready = 1'b0;
        check_val("cc_bvalid_clr", 32'(bus.bvalid), 32'd0);
        check_val("cc_rvalid", 32'(bus.rvalid), 32'd1);
        check_val("cc_rdata", bus.rdata, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            tick;
            check_val("cc_rvalid_hold", 32'(bus.rvalid), 32'd1);
            check_val("cc_rdata_hold", bus.rdata, 32'hDEADBEEF);
        end
        bus.rready = 1'b1;
        tick;
        bus.rready = 1'b0;
        check_val("cc_rvalid_clr", 32'(bus.rvalid), 32'd0);
        check_val("cc_arready_back", 32'(bus.arready), 32'd1);
        $display("[TB] concurrent write 0x00040 / read 0x00010 rdata=0xdeadbeef");
        do_read(20'h00040, 32'h01020304, 2'b00);

        // Reset while the write is waiting: it must never commit
        do_write(20'h00050, 32'h77777777, 4'hF, 2'b00);
        bus.awaddr = 20'h00050; bus.wdata = 32'h88888888; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        areset_n = 1'b0;
        tick;
        check_val("mrst_bvalid", 32'(bus.bvalid), 32'd0);
        check_val("mrst_awready", 32'(bus.awready), 32'd0);
        check_val("mrst_wready", 32'(bus.wready), 32'd0);
        check_val("mrst_arready", 32'(bus.arready), 32'd0);
        tick;
        check_val("mrst_bvalid2", 32'(bus.bvalid), 32'd0);
        areset_n = 1'b1;
        tick;
        check_val("mrst_rel_awready", 32'(bus.awready), 32'd1);
        check_val("mrst_rel_wready", 32'(bus.wready), 32'd1);
        check_val("mrst_rel_arready", 32'(bus.arready), 32'd1);
        tick; tick; tick;
        check_val("mrst_no_late_bvalid", 32'(bus.bvalid), 32'd0);
        $display("[TB] reset during W_WAIT addr=0x00050");
        do_read(20'h00050, 32'h77777777, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/axi4lite_responder_mem.md
Name: axi4lite_responder_mem

Overview:
- Synthesizable AXI4-Lite subordinate with a word-addressed memory, programmable wait states and an error response for out-of-range accesses.
- It is the responder on the far end of the co-simulation bus controller. Renode-issued reads and writes terminate here in HDL-only testbenches and example designs.
- Read and write channels are independent.

Parameters:
- AddressWidth, 20, width of awaddr/araddr.
- DataWidth, 32, data width; only 32 is supported (elaboration error otherwise).
- MemoryDepth, 1024, number of DataWidth words.
- BaseAddress, 0, byte address of word 0.
- ReadLatency, 2, idle cycles between the AR handshake and rvalid assertion (0..15).
- WriteLatency, 1, idle cycles between capture of both AW and W and bvalid assertion (0..15).

Ports:
- clk  in  1  clock, all logic on rising edge
- areset_n  in  1  synchronous active-low reset
- awvalid / awready  in / out  1 / 1  write address handshake
- awaddr  in  AddressWidth  write byte address
- awprot  in  3  ignored
- wvalid / wready  in / out  1 / 1  write data handshake
- wdata  in  DataWidth  write data
- wstrb  in  DataWidth/8  byte enables
- bvalid / bready  out / in  1 / 1  write response handshake
- bresp  out  2  00 OKAY, 10 SLVERR
- arvalid / arready  in / out  1 / 1  read address handshake
- araddr  in  AddressWidth  read byte address
- arprot  in  3  ignored
- rvalid / rready  out / in  1 / 1  read response handshake
- rdata  out  DataWidth  read data
- rresp  out  2  00 OKAY, 10 SLVERR

Behaviour:
- Reset (areset_n=0 at a rising edge):
  - All outputs go to 0: ready signals, valid signals, bresp, rresp, rdata.
  - Both FSMs return to IDLE. Latency counters clear. Captured address/data flags clear.
  - Memory contents are not reset.
- Reset mid-transaction drops any pending response. A write not yet committed is never written.
- Address decode:
  - offset = addr - BaseAddress, computed in AddressWidth+1 bits.
  - In range if addr >= BaseAddress and offset[AddressWidth-1:2] < MemoryDepth.
  - addr[1:0] is ignored.
- Write FSM states: W_IDLE, W_WAIT, W_RESP.
  - W_IDLE:
    - awready=1 until AW is captured; wready=1 until W is captured.
    - AW and W may arrive in either order or in the same cycle. Each is captured independently; its ready drops in the cycle after its handshake.
    - When both are captured (including the same-cycle case): go to W_WAIT with counter=WriteLatency. If WriteLatency=0, go directly to W_RESP.
  - W_WAIT: counter decrements each cycle; at 0, go to W_RESP.
  - Entering W_RESP: commit the write. If in range, write the bytes enabled by wstrb (wstrb=0 writes nothing, still OKAY) and set bresp=00. If out of range, do not write and set bresp=10. Assert bvalid.
  - W_RESP: hold bvalid and bresp stable until bready=1. On the handshake, clear bvalid, go to W_IDLE, and raise awready/wready the next cycle.
- Read FSM states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready=1. On the handshake, capture araddr, drop arready, go to R_WAIT with counter=ReadLatency (or directly to R_RESP if 0).
  - Entering R_RESP: sample memory into rdata. If out of range, rdata=0 and rresp=10. Assert rvalid.
  - R_RESP: hold rvalid, rdata and rresp stable until rready. On the handshake, go to R_IDLE; arready=1 the next cycle.
- Minimum latency, AR handshake to rvalid: ReadLatency+1 cycles.
- Read/write collision: if the read sample and the write commit hit the same word in the same cycle, the read returns the old data.
- Throughput: at most one outstanding transaction per channel. No interleaving within a channel.
- valid signals from the manager are never required to stay stable while the corresponding ready is low in IDLE.

Test Plan:
- Write then read, defaults: AW and W in the same cycle, awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF -> bvalid 2 cycles after the handshake with bresp=00. Then AR at 0x10 -> rvalid 3 cycles after the AR handshake, rdata=0xDEADBEEF, rresp=00.
- Byte strobes: word 0x20 holds 0x11223344; write 0xAABBCCDD with wstrb=0x5 -> read 0x20 returns 0x11BB33DD.
- Split write ordering: W handshake 3 cycles before AW -> wready low after the W handshake, awready still high. The write commits only after AW. bvalid is held for 4 cycles while bready=0, with bresp stable throughout.
- Out of range: write to BaseAddress+4*MemoryDepth -> bresp=10 and memory unchanged (read of word 0 is unaffected). Read from the same address -> rresp=10, rdata=0.
- Backpressure and concurrency: AR and AW/W issued in the same cycle to different words, rready held low for 5 cycles -> both complete independently, with rdata stable during the stall.
- Reset mid-operation: assert areset_n=0 while in W_WAIT -> bvalid=0 and all ready signals 0 during reset; the word is not modified; awready/wready/arready are 1 in the first cycle after release.
